// File: rtl/bin_to_bcd_seq_if.sv
// Handshake bundle for the sequential binary-to-BCD converter.
// master drives the request (start/din); slave is the converter itself.
interface bin_to_bcd_seq_if #(
   parameter int BIN_W  = 8,
   parameter int DIGITS = 2
);
   logic                  start;
   logic [BIN_W-1:0]      din;
   logic                  busy;
   logic                  done;
   logic [4*DIGITS-1:0]   bcd;
   logic                  ovf;

   modport master (output start, din, input  busy, done, bcd, ovf);
   modport slave  (input  start, din, output busy, done, bcd, ovf);
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: one input bit per SHIFT cycle,
// result registered on the final shift so bcd/ovf only move on entry to DONE.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for start; bcd/ovf hold the last result
//   ST_SHIFT | converting, one add-3/shift per cycle, counter counts down
//   ST_DONE  | one-cycle result strobe; a start here chains a new conversion
module bin_to_bcd_seq #(
   parameter int BIN_W  = 8,
   parameter int DIGITS = 2
) (
   input  logic             clk,
   input  logic             rst,
   bin_to_bcd_seq_if.slave  bus
);
   localparam int SCR_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(BIN_W + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_W);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;

   state_t             state_q, state_d;
   logic [BIN_W-1:0]   bin_q, bin_d;
   logic [SCR_W-1:0]   scr_q, scr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ovf_q, ovf_d;
   logic [SCR_W-1:0]   bcd_q, bcd_d;
   logic               res_ovf_q, res_ovf_d;

   logic [SCR_W-1:0]   adj;
   logic [SCR_W-1:0]   scr_shift;
   logic [BIN_W-1:0]   bin_shift;
   logic               carry;
   logic               accept;
   logic               last_shift;

   // start is ignored while a conversion is running
   assign accept     = bus.start && (state_q != ST_SHIFT);
   assign last_shift = (state_q == ST_SHIFT) && (cnt_q == CNT_ONE);

   // add-3 correction on every scratch digit that would overflow when doubled
   always_comb begin
      adj = scr_q;
      for (int k = 0; k < DIGITS; k++) begin
         if (scr_q[4*k +: 4] >= 4'd5) begin
            adj[4*k +: 4] = scr_q[4*k +: 4] + 4'd3;
         end
      end
   end

   // the bit leaving the top digit is dropped from bcd but remembered as overflow
   assign carry     = adj[SCR_W-1];
   assign scr_shift = {adj[SCR_W-2:0], bin_q[BIN_W-1]};
   assign bin_shift = {bin_q[BIN_W-2:0], 1'b0};

   // state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (bus.start) state_d = ST_SHIFT;
         ST_SHIFT: if (last_shift) state_d = ST_DONE;
         ST_DONE:  state_d = bus.start ? ST_SHIFT : ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // datapath next values: load on accept, shift while converting, publish on the last shift
   always_comb begin
      bin_d     = bin_q;
      scr_d     = scr_q;
      cnt_d     = cnt_q;
      ovf_d     = ovf_q;
      bcd_d     = bcd_q;
      res_ovf_d = res_ovf_q;
      if (accept) begin
         bin_d = bus.din;
         scr_d = '0;
         ovf_d = 1'b0;
         cnt_d = CNT_LOAD;
      end else if (state_q == ST_SHIFT) begin
         bin_d = bin_shift;
         scr_d = scr_shift;
         ovf_d = ovf_q | carry;
         cnt_d = cnt_q - CNT_ONE;
         if (cnt_q == CNT_ONE) begin
            bcd_d     = scr_shift;
            res_ovf_d = ovf_q | carry;
         end
      end
   end

   // datapath registers; reset clears everything, including any partial result
   always_ff @(posedge clk) begin
      if (rst) begin
         bin_q     <= '0;
         scr_q     <= '0;
         cnt_q     <= '0;
         ovf_q     <= 1'b0;
         bcd_q     <= '0;
         res_ovf_q <= 1'b0;
      end else begin
         bin_q     <= bin_d;
         scr_q     <= scr_d;
         cnt_q     <= cnt_d;
         ovf_q     <= ovf_d;
         bcd_q     <= bcd_d;
         res_ovf_q <= res_ovf_d;
      end
   end

   assign bus.busy = (state_q == ST_SHIFT);
   assign bus.done = (state_q == ST_DONE);
   assign bus.bcd  = bcd_q;
   assign bus.ovf  = res_ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: a 2-digit and a 3-digit instance share one stimulus
// stream; expected results come from decimal arithmetic on din.
module tb_bin_to_bcd_seq;
   logic clk = 1'b0;
   logic rst;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [7:0]  last2;
   logic [11:0] last3;

   bin_to_bcd_seq_if #(.BIN_W(8), .DIGITS(2)) if2 ();
   bin_to_bcd_seq_if #(.BIN_W(8), .DIGITS(3)) if3 ();

   assign if3.start = if2.start;
   assign if3.din   = if2.din;

   bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));
   bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut3 (.clk(clk), .rst(rst), .bus(if3.slave));

   always #5 clk = ~clk;

   function automatic logic [11:0] ref_bcd(input int v, input int digits);
      logic [11:0] r;
      int p;
      r = '0;
      p = v;
      for (int k = 0; k < digits; k++) begin
         r[4*k +: 4] = 4'(p % 10);
         p = p / 10;
      end
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // inj > 0 pulses a second start (with inj_din) on the inj-th edge after acceptance
   task automatic conv(input logic [7:0] d, input int inj, input logic [7:0] inj_din);
      logic [11:0] e2, e3;
      if2.start = 1'b1;
      if2.din   = d;
      tick();
      if2.start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk("busy2", 32'(if2.busy), 1);
         chk("busy3", 32'(if3.busy), 1);
         chk("done_early", 32'(if2.done), 0);
         chk("hold2", 32'(if2.bcd), 32'(last2));
         chk("hold3", 32'(if3.bcd), 32'(last3));
         if (i == inj - 1) begin
            if2.start = 1'b1;
            if2.din   = inj_din;
         end else begin
            if2.start = 1'b0;
         end
         tick();
      end
      if2.start = 1'b0;
      e2 = ref_bcd(int'(d), 2);
      e3 = ref_bcd(int'(d), 3);
      chk("done2", 32'(if2.done), 1);
      chk("done3", 32'(if3.done), 1);
      chk("busy_at_done", 32'(if2.busy), 0);
      chk("bcd2", 32'(if2.bcd), 32'(e2[7:0]));
      chk("ovf2", 32'(if2.ovf), 32'(d > 8'd99));
      chk("bcd3", 32'(if3.bcd), 32'(e3));
      chk("ovf3", 32'(if3.ovf), 0);
      last2 = e2[7:0];
      last3 = e3;
   endtask

   task automatic idle_check();
      tick();
      chk("done_pulse_len", 32'(if2.done), 0);
      chk("busy_idle", 32'(if2.busy), 0);
      chk("idle_hold2", 32'(if2.bcd), 32'(last2));
      chk("idle_hold3", 32'(if3.bcd), 32'(last3));
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_busy"}, 32'(if2.busy), 0);
      chk({tag, "_done"}, 32'(if2.done), 0);
      chk({tag, "_bcd2"}, 32'(if2.bcd), 0);
      chk({tag, "_ovf2"}, 32'(if2.ovf), 0);
      chk({tag, "_bcd3"}, 32'(if3.bcd), 0);
      chk({tag, "_busy3"}, 32'(if3.busy), 0);
   endtask

   initial begin
      logic [7:0] d;
      logic [7:0] d2;
      int         inj;
      rst       = 1'b1;
      if2.start = 1'b0;
      if2.din   = '0;
      last2     = '0;
      last3     = '0;
      repeat (3) tick();
      chk_zero("reset");

      // rst wins over a simultaneous start
      if2.start = 1'b1;
      if2.din   = 8'd77;
      tick();
      chk_zero("rst_vs_start");
      rst       = 1'b0;
      if2.start = 1'b0;
      tick();
      chk_zero("after_rst");

      // directed values, including back-to-back chains from DONE
      conv(8'd99, -1, 8'd0);
      idle_check();
      conv(8'd255, -1, 8'd0);
      conv(8'd0, -1, 8'd0);
      conv(8'd10, -1, 8'd0);
      idle_check();

      // start during SHIFT is ignored, then chained start from DONE
      conv(8'd37, 4, 8'd50);
      conv(8'd50, -1, 8'd0);
      idle_check();

      // reset in the middle of a conversion aborts it
      if2.start = 1'b1;
      if2.din   = 8'd88;
      tick();
      if2.start = 1'b0;
      repeat (4) tick();
      rst = 1'b1;
      tick();
      chk_zero("abort");
      rst   = 1'b0;
      last2 = '0;
      last3 = '0;
      conv(8'd42, -1, 8'd0);
      idle_check();

      // randomized values with random mid-conversion starts and gaps
      for (int n = 0; n < 40; n++) begin
         d   = 8'($urandom_range(0, 255));
         d2  = 8'($urandom_range(0, 255));
         inj = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 8)) : -1;
         conv(d, inj, d2);
         if ($urandom_range(0, 2) == 0) idle_check();
      end

      // full sweep, back-to-back
      for (int v = 0; v < 256; v++) begin
         conv(8'(v), -1, 8'd0);
      end
      idle_check();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/bin_to_bcd_seq.md
BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

Interface
REQ-001 Parameter BIN_W, default 8: width of the binary input in bits, legal range 4..16.
REQ-002 Parameter DIGITS, default 2: number of BCD digits produced, legal range 1..5.
REQ-003 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port start, input, 1: request to convert din; sampled on rising edge of clk.
REQ-006 Port din, input, BIN_W: unsigned binary value; captured on the cycle start is accepted.
REQ-007 Port busy, output, 1: high while a conversion is in progress.
REQ-008 Port done, output, 1: one-cycle pulse marking that bcd and ovf are valid for the new result.
REQ-009 Port bcd, output, 4*DIGITS: packed BCD result; digit k (ones = k0) occupies bits [4k+3:4k].
REQ-010 Port ovf, output, 1: high when din exceeded 10^DIGITS-1.

Function
REQ-011 The FSM SHALL have three states, IDLE, SHIFT and DONE.
REQ-012 Transitions SHALL be: IDLE->SHIFT on start; SHIFT->SHIFT until BIN_W shifts are complete; SHIFT->DONE after shift BIN_W; DONE->SHIFT on start; DONE->IDLE otherwise.
REQ-013 start SHALL be accepted only in IDLE or DONE; start in SHIFT SHALL be ignored, with no queuing and no effect on the conversion in progress.
REQ-014 On acceptance, din SHALL be loaded into an internal shift register, the BCD scratch register SHALL be cleared, the internal overflow flag SHALL be cleared, and the shift counter SHALL be set to BIN_W.
REQ-015 Each SHIFT cycle SHALL run in this order:
- add 3 to every scratch digit whose value is >=5;
- shift {scratch, binary} left by one bit, with the binary MSB entering scratch bit 0;
- decrement the counter.
REQ-016 A 1 shifted out of the top scratch digit SHALL set the internal overflow flag, and the flag SHALL stay set until the next acceptance.
REQ-017 The scratch register SHALL be exactly 4*DIGITS bits wide; bits shifted out of the top digit SHALL be discarded, so bcd = din mod 10^DIGITS.
REQ-018 busy SHALL be high exactly in SHIFT: from the cycle after acceptance through the last shift cycle.
REQ-019 bcd and ovf SHALL update only on entry to DONE, and SHALL hold their value until the next entry to DONE.
- They SHALL NOT change during a later conversion.
REQ-020 done SHALL be high for exactly the one cycle spent in DONE; its rising edge SHALL come BIN_W+1 cycles after the start-acceptance edge.
REQ-021 A start accepted in DONE SHALL begin a new conversion on the next edge, giving back-to-back throughput of one result per BIN_W+1 cycles.
REQ-022 When rst and start are high on the same edge, rst SHALL win and start SHALL be ignored.
REQ-023 The block SHALL never emit a digit value above 9 on bcd.

Reset
REQ-024 When rst is high at an edge, the FSM SHALL go to IDLE and busy, done, ovf and bcd SHALL all be 0.
- The internal registers and counter SHALL also be 0.
REQ-025 Reset during SHIFT SHALL abort the conversion.
- No done pulse SHALL be produced.
- bcd SHALL read 0, not a partial result.
REQ-026 In the first cycle after rst deasserts, the block SHALL accept start.

Verification (BIN_W=8, DIGITS=2 unless noted)
REQ-027 din=8'd99, start pulsed at edge 0: busy high at edges 1-8, done high at edge 9 only, bcd=8'h99, ovf=0.
REQ-028 din=8'd255: bcd=8'h55, ovf=1, done after 9 cycles; with DIGITS=3 the same din gives bcd=12'h255, ovf=0.
REQ-029 din=8'd0, then din=8'd10: bcd=8'h00 then bcd=8'h10, both with ovf=0.
REQ-030 Start with din=8'd37, then start with din=8'd50 at edge 4: the second start is ignored; result bcd=8'h37 at edge 9.
- A follow-up start at edge 9 with din=8'd50 gives bcd=8'h50 at edge 18.
REQ-031 rst asserted at edge 5 of a conversion of din=8'd88: no done pulse; bcd=0, busy=0 from edge 5.
- A new start at edge 6 with din=8'd42 yields done at edge 15 with bcd=8'h42.
REQ-032 Exhaustive sweep din=0..255: each result satisfies bcd = din mod 100 and ovf = (din>99).
